// File: rtl/uop_pkg.sv
// rtl/uop_pkg.sv - shared uop type and queue sizing constants
//
// Purpose: defines the cracked micro-op record carried from decode to
// rename/dispatch, and the default sizing of the uop instruction queue.
// Ports: none (package).

package uop_pkg;

  localparam int INSTR_Q_DEPTH = 16;  // queue entries
  localparam int INSTR_Q_WIDTH = 4;   // max pushes per cycle
  localparam int ISSUE_WIDTH   = 2;   // max pops per cycle
  localparam int MAX_TX_LEN    = 2;   // longest cracked transaction in uops

  // tx_begin marks the first uop of a cracked instruction, tx_end the last;
  // a single-uop instruction carries both.
  typedef struct packed {
    logic [15:0] opcode;
    logic        tx_begin;
    logic        tx_end;
  } uop_insn;

endpackage

// File: rtl/uop_q_window.sv
// rtl/uop_q_window.sv - pop window sizing that never splits a transaction
//
// Purpose: given the tx_end flags of the oldest ISSUE_WIDTH entries and the
// number of them that are actually occupied, picks the largest group size
// that ends on a transaction boundary.
// Ports:
//   head_tx_end  in   tx_end of entries head .. head+ISSUE_WIDTH-1
//   avail        in   occupied entries visible in the window (<= ISSUE_WIDTH)
//   pop_count    out  uops that may be offered downstream (0 if none)

module uop_q_window
  import uop_pkg::*;
#(
  parameter int ISSUE_WIDTH = uop_pkg::ISSUE_WIDTH
) (
  input  logic [ISSUE_WIDTH-1:0]           head_tx_end,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0] avail,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0] pop_count
);

  localparam int POP_W = $clog2(ISSUE_WIDTH + 1);

  // Later (larger) qualifying k overrides earlier ones, giving the maximum.
  always_comb begin
    pop_count = '0;
    for (int k = 1; k <= ISSUE_WIDTH; k++) begin
      if ((POP_W'(k) <= avail) && head_tx_end[k-1]) begin
        pop_count = POP_W'(k);
      end
    end
  end

endmodule

// File: rtl/uop_instr_queue.sv
// rtl/uop_instr_queue.sv - circular micro-op queue between decode and dispatch
//
// Purpose: accepts all-or-nothing pushes of up to INSTR_Q_WIDTH uops, offers
// up to ISSUE_WIDTH uops per cycle ending on a transaction boundary, owns
// decode backpressure and drops everything on flush.
// Ports:
//   clk_in          in   clock
//   rst_N_in        in   asynchronous active-low reset
//   flush_in        in   synchronous flush, discards all entries
//   push_count_in   in   valid uops in push_uops_in, packed from index 0
//   push_uops_in    in   uops in program order
//   push_ready_out  out  room for a full-width push this cycle
//   pop_valid_out   out  pop_count_out > 0
//   pop_count_out   out  uops offered from the head
//   pop_uops_out    out  offered uops, unused slots zero
//   pop_ready_in    in   downstream takes every offered uop
//   count_out       out  current occupancy
//   tx_err_out      out  sticky: head entry seen without tx_begin

module uop_instr_queue
  import uop_pkg::*;
#(
  parameter int INSTR_Q_DEPTH = uop_pkg::INSTR_Q_DEPTH,
  parameter int INSTR_Q_WIDTH = uop_pkg::INSTR_Q_WIDTH,
  parameter int ISSUE_WIDTH   = uop_pkg::ISSUE_WIDTH
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               flush_in,
  input  logic [$clog2(INSTR_Q_WIDTH+1)-1:0] push_count_in,
  input  uop_insn [INSTR_Q_WIDTH-1:0]        push_uops_in,
  output logic                               push_ready_out,
  output logic                               pop_valid_out,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0]   pop_count_out,
  output uop_insn [ISSUE_WIDTH-1:0]          pop_uops_out,
  input  logic                               pop_ready_in,
  output logic [$clog2(INSTR_Q_DEPTH+1)-1:0] count_out,
  output logic                               tx_err_out
);

  localparam int PTR_W  = $clog2(INSTR_Q_DEPTH);
  localparam int CNT_W  = $clog2(INSTR_Q_DEPTH + 1);
  localparam int PUSH_W = $clog2(INSTR_Q_WIDTH + 1);
  localparam int POP_W  = $clog2(ISSUE_WIDTH + 1);

  // Highest occupancy that still leaves room for a full-width push.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(INSTR_Q_DEPTH - INSTR_Q_WIDTH);

  if ((INSTR_Q_DEPTH & (INSTR_Q_DEPTH - 1)) != 0) begin : g_bad_depth_pow2
    $error("uop_instr_queue: INSTR_Q_DEPTH must be a power of 2");
  end
  if (INSTR_Q_DEPTH < INSTR_Q_WIDTH + ISSUE_WIDTH) begin : g_bad_depth_size
    $error("uop_instr_queue: INSTR_Q_DEPTH too small for push plus issue width");
  end
  if (ISSUE_WIDTH < uop_pkg::MAX_TX_LEN) begin : g_bad_issue_width
    $error("uop_instr_queue: ISSUE_WIDTH must cover the longest transaction");
  end

  uop_insn                   entries [INSTR_Q_DEPTH];
  logic    [PTR_W-1:0]       head;
  logic    [PTR_W-1:0]       tail;
  logic    [CNT_W-1:0]       count;
  logic                      tx_err;

  uop_insn [ISSUE_WIDTH-1:0] head_uops;
  logic    [ISSUE_WIDTH-1:0] head_tx_end;
  logic    [POP_W-1:0]       avail;
  logic    [POP_W-1:0]       window_count;
  logic                      push_fire;
  logic                      pop_fire;
  logic    [PUSH_W-1:0]      push_amt;
  logic    [POP_W-1:0]       pop_amt;

  always_comb begin
    head_uops   = '0;
    head_tx_end = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      head_uops[i]   = entries[head + PTR_W'(i)];
      head_tx_end[i] = head_uops[i].tx_end;
    end
  end

  assign avail = (count >= CNT_W'(ISSUE_WIDTH)) ? POP_W'(ISSUE_WIDTH) : POP_W'(count);

  uop_q_window #(
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_window (
    .head_tx_end (head_tx_end),
    .avail       (avail),
    .pop_count   (window_count)
  );

  // rst_N_in gates ready so decode sees backpressure while reset is held.
  assign push_ready_out = rst_N_in & ~flush_in & (count <= READY_MAX);
  assign pop_count_out  = flush_in ? '0 : window_count;
  assign pop_valid_out  = (pop_count_out != '0);
  assign count_out      = count;
  assign tx_err_out     = tx_err;

  always_comb begin
    pop_uops_out = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (POP_W'(i) < pop_count_out) begin
        pop_uops_out[i] = head_uops[i];
      end
    end
  end

  assign push_fire = push_ready_out & (push_count_in != '0);
  assign pop_fire  = pop_valid_out & pop_ready_in;
  assign push_amt  = push_fire ? push_count_in : '0;
  assign pop_amt   = pop_fire ? pop_count_out : '0;

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_amt);
      tail  <= tail + PTR_W'(push_amt);
      count <= count + CNT_W'(push_amt) - CNT_W'(pop_amt);
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk_in) begin
    if (push_fire) begin
      for (int i = 0; i < INSTR_Q_WIDTH; i++) begin
        if (PUSH_W'(i) < push_count_in) begin
          entries[tail + PTR_W'(i)] <= push_uops_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      tx_err <= 1'b0;
    end else if ((count != '0) && !head_uops[0].tx_begin) begin
      tx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uop_instr_queue.sv
// tb/tb_uop_instr_queue.sv - directed self-checking bench for uop_instr_queue

module tb_uop_instr_queue;
  import uop_pkg::*;

  logic          clk_in = 1'b0;
  logic          rst_N_in;
  logic          flush_in;
  logic [2:0]    push_count_in;
  uop_insn [3:0] push_uops_in;
  logic          push_ready_out;
  logic          pop_valid_out;
  logic [1:0]    pop_count_out;
  uop_insn [1:0] pop_uops_out;
  logic          pop_ready_in;
  logic [4:0]    count_out;
  logic          tx_err_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q [$];
  logic [15:0] next_op = 16'h0100;

  always #5 clk_in = ~clk_in;

  uop_instr_queue dut (
    .clk_in         (clk_in),
    .rst_N_in       (rst_N_in),
    .flush_in       (flush_in),
    .push_count_in  (push_count_in),
    .push_uops_in   (push_uops_in),
    .push_ready_out (push_ready_out),
    .pop_valid_out  (pop_valid_out),
    .pop_count_out  (pop_count_out),
    .pop_uops_out   (pop_uops_out),
    .pop_ready_in   (pop_ready_in),
    .count_out      (count_out),
    .tx_err_out     (tx_err_out)
  );

  always @(posedge clk_in) begin
    if (rst_N_in) assert (push_count_in <= 3'd4) else $error("illegal push_count_in %0d", push_count_in);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic uop_insn mk(input logic [15:0] op, input logic b, input logic e);
    uop_insn u;
    u.opcode   = op;
    u.tx_begin = b;
    u.tx_end   = e;
    return u;
  endfunction

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic push_singles(input int n);
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        push_uops_in[i] = mk(next_op, 1'b1, 1'b1);
        exp_q.push_back(next_op);
        next_op++;
      end else begin
        push_uops_in[i] = '0;
      end
    end
    push_count_in = 3'(n);
    step();
    push_count_in = '0;
  endtask

  task automatic drain();
    int guard;
    int e;
    guard = 0;
    pop_ready_in = 1'b1;
    while (exp_q.size() > 0 && guard < 40) begin
      e = (exp_q.size() >= 2) ? 2 : exp_q.size();
      chk("drain_cnt", 64'(pop_count_out), 64'(e));
      for (int i = 0; i < e; i++) chk("drain_op", 64'(pop_uops_out[i].opcode), 64'(exp_q.pop_front()));
      step();
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    pop_ready_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_N_in      = 1'b0;
    flush_in      = 1'b0;
    push_count_in = '0;
    push_uops_in  = '0;
    pop_ready_in  = 1'b0;

    // Reset state
    step();
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_ready", 64'(push_ready_out), 64'd0);
    chk("rst_pvalid", 64'(pop_valid_out), 64'd0);
    chk("rst_pcount", 64'(pop_count_out), 64'd0);
    chk("rst_puops", 64'(pop_uops_out), 64'd0);
    chk("rst_txerr", 64'(tx_err_out), 64'd0);
    rst_N_in = 1'b1;
    step();
    chk("idle_ready", 64'(push_ready_out), 64'd1);
    chk("idle_count", 64'(count_out), 64'd0);
    chk("idle_pvalid", 64'(pop_valid_out), 64'd0);

    // Three single-uop transactions A, B, C
    pop_ready_in    = 1'b1;
    push_uops_in[0] = mk(16'h00A1, 1'b1, 1'b1);
    push_uops_in[1] = mk(16'h00B2, 1'b1, 1'b1);
    push_uops_in[2] = mk(16'h00C3, 1'b1, 1'b1);
    push_uops_in[3] = '0;
    push_count_in   = 3'd3;
    step();
    push_count_in = '0;
    chk("abc_pcount1", 64'(pop_count_out), 64'd2);
    chk("abc_op_a", 64'(pop_uops_out[0].opcode), 64'h00A1);
    chk("abc_op_b", 64'(pop_uops_out[1].opcode), 64'h00B2);
    chk("abc_count1", 64'(count_out), 64'd3);
    step();
    chk("abc_pcount2", 64'(pop_count_out), 64'd1);
    chk("abc_op_c", 64'(pop_uops_out[0].opcode), 64'h00C3);
    chk("abc_slot1_zero", 64'(pop_uops_out[1]), 64'd0);
    chk("abc_count2", 64'(count_out), 64'd1);
    step();
    chk("abc_empty", 64'(count_out), 64'd0);
    chk("abc_pvalid", 64'(pop_valid_out), 64'd0);

    // LDUR crack behind single uop X
    push_uops_in[0] = mk(16'h0E01, 1'b1, 1'b1);
    push_uops_in[1] = mk(16'h0AD0, 1'b1, 1'b0);
    push_uops_in[2] = mk(16'h010A, 1'b0, 1'b1);
    push_count_in   = 3'd3;
    step();
    push_count_in = '0;
    chk("ldur_pcount1", 64'(pop_count_out), 64'd1);
    chk("ldur_op_x", 64'(pop_uops_out[0].opcode), 64'h0E01);
    chk("ldur_slot1_zero", 64'(pop_uops_out[1]), 64'd0);
    step();
    chk("ldur_pcount2", 64'(pop_count_out), 64'd2);
    chk("ldur_op_add", 64'(pop_uops_out[0].opcode), 64'h0AD0);
    chk("ldur_op_load", 64'(pop_uops_out[1].opcode), 64'h010A);
    step();
    chk("ldur_empty", 64'(count_out), 64'd0);
    pop_ready_in = 1'b0;

    // Move pointers from 6 to 1 so the later 4-push straddles the wrap
    push_singles(4);
    push_singles(4);
    push_singles(3);
    drain();

    // Fill to 13 with no pops
    push_singles(4);
    push_singles(4);
    push_singles(4);
    chk("fill12_ready", 64'(push_ready_out), 64'd1);
    push_singles(1);
    chk("fill13_count", 64'(count_out), 64'd13);
    chk("fill13_ready", 64'(push_ready_out), 64'd0);
    chk("fill13_pvalid", 64'(pop_valid_out), 64'd1);
    drain();

    // Four entries at slots 14, 15, 0, 1
    push_singles(4);
    chk("wrap_count", 64'(count_out), 64'd4);
    drain();

    // Simultaneous push 4 / pop 2 at count 6, then flush with a push
    push_singles(4);
    push_singles(2);
    chk("sim_count6", 64'(count_out), 64'd6);
    pop_ready_in = 1'b1;
    chk("sim_pcount", 64'(pop_count_out), 64'd2);
    chk("sim_op0", 64'(pop_uops_out[0].opcode), 64'(exp_q.pop_front()));
    chk("sim_op1", 64'(pop_uops_out[1].opcode), 64'(exp_q.pop_front()));
    push_singles(4);
    chk("sim_count8", 64'(count_out), 64'd8);
    flush_in      = 1'b1;
    push_count_in = 3'd4;
    #1;
    chk("flush_ready", 64'(push_ready_out), 64'd0);
    chk("flush_pvalid", 64'(pop_valid_out), 64'd0);
    step();
    flush_in      = 1'b0;
    push_count_in = '0;
    pop_ready_in  = 1'b0;
    chk("flush_count", 64'(count_out), 64'd0);
    chk("flush_pvalid_after", 64'(pop_valid_out), 64'd0);
    step();
    chk("flush_push_dropped", 64'(count_out), 64'd0);
    exp_q.delete();

    // Head entry without tx_begin
    chk("txerr_clean", 64'(tx_err_out), 64'd0);
    push_uops_in[0] = mk(16'h0BAD, 1'b0, 1'b1);
    push_count_in   = 3'd1;
    step();
    push_count_in = '0;
    chk("txerr_not_yet", 64'(tx_err_out), 64'd0);
    chk("txerr_count", 64'(count_out), 64'd1);
    step();
    chk("txerr_set", 64'(tx_err_out), 64'd1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("txerr_thru_flush", 64'(tx_err_out), 64'd1);
    chk("txerr_flush_count", 64'(count_out), 64'd0);
    step();
    chk("txerr_sticky", 64'(tx_err_out), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
